// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction memory,
// buffers in-order responses in a small FIFO and drops stale responses after a redirect.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] LIMIT = (AW+2)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [AW:0]   out_cnt;
    logic [AW:0]   drop_cnt;
    logic [AW:0]   fifo_cnt;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    entry_t        mem [DEPTH];

    logic        req_fire;
    logic        rsp_fire;
    logic        push;
    logic        pop;
    logic [31:0] target;

    assign target = redirect_pc & ~32'd3;

    // Reserving a FIFO slot for every in-flight request lets responses arrive without backpressure.
    assign imem_req_valid = reset && !redirect
                         && (({1'b0, out_cnt} + {1'b0, fifo_cnt}) < LIMIT);
    assign imem_addr = pc;
    assign req_fire  = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire = imem_rsp_valid && (out_cnt != '0);
    assign push     = rsp_fire && !redirect && (drop_cnt == '0);
    assign pop      = inst_valid && inst_ready && !redirect;

    assign inst_valid = (fifo_cnt != '0);
    assign inst       = inst_valid ? mem[rd_ptr].word : '0;
    assign inst_pc    = inst_valid ? mem[rd_ptr].pc   : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
            fifo_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            out_cnt <= out_cnt + (AW+1)'(req_fire) - (AW+1)'(rsp_fire);
            if (redirect) begin
                pc       <= target;
                rsp_pc   <= target;
                drop_cnt <= out_cnt - (AW+1)'(rsp_fire);
                fifo_cnt <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire)
                    pc <= pc + 32'd4;
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (rsp_fire && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - (AW+1)'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

    // NOTE: storage is not reset; fifo_cnt gates every read, so stale contents are never visible.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= '{pc: rsp_pc, word: imem_rsp_data};
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage: the front end that produces the 32-bit `inst` word the decode/control block consumes, and that consumes the decoder's resolved branch/jump decision (`brn_tkn`) plus target address as a redirect. It owns the PC, issues requests to instruction memory over a valid/ready request channel, and accepts in-order variable-latency responses. It buffers fetched words in a small FIFO and presents them downstream with a valid/ready handshake. Stale responses after a redirect are discarded.

## Interface
- `RESET_PC`, 32'h0100_0000, address of the first fetch after reset
- `DEPTH`, 4, FIFO entries and maximum in-flight requests; power of two, ≥2

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; asserting (0) resets all state immediately
- `redirect`  in  1  branch/jump taken (decoder `brn_tkn` qualified by a valid instruction)
- `redirect_pc`  in  32  target address; bits [1:0] are ignored and treated as 0
- `imem_req_valid`  out  1  request valid
- `imem_req_ready`  in  1  memory accepts the request
- `imem_addr`  out  32  request address, word aligned
- `imem_rsp_valid`  in  1  response valid, in request order, never in the same cycle the request is accepted
- `imem_rsp_data`  in  32  fetched word
- `inst_valid`  out  1  FIFO head valid
- `inst_ready`  in  1  downstream consumes head
- `inst`  out  32  head instruction word; 0 when empty
- `inst_pc`  out  32  PC of head word; 0 when empty

## Operation
- State: `pc` (next request address), `rsp_pc` (PC of next non-stale response), `out_cnt` (in flight, 0..DEPTH), `drop_cnt` (stale in flight), FIFO of {pc, word} with rd/wr pointers and count.
- Request: `imem_req_valid = !redirect && (out_cnt + fifo_count) < DEPTH`, so every response is guaranteed a FIFO slot and `imem_rsp_valid` has no backpressure. `imem_addr = pc`. On handshake, `pc <= pc + 4` (wraps mod 2^32) and `out_cnt` increments.
- Response: on `imem_rsp_valid`, `out_cnt` decrements. If `drop_cnt > 0`, the word is discarded and `drop_cnt` decrements. Otherwise {`rsp_pc`, data} is pushed and `rsp_pc <= rsp_pc + 4`.
- Output: the head is shown on `inst`/`inst_pc`. The head pops when `inst_valid && inst_ready`.
- Redirect (highest priority):
  - `pc <= redirect_pc & ~3` and `rsp_pc <= redirect_pc & ~3`.
  - The FIFO is flushed (count 0). A pop in the same cycle has no further effect.
  - No request is issued that cycle.
  - `drop_cnt <= out_cnt - imem_rsp_valid`; any response arriving in the redirect cycle is itself discarded. `out_cnt` updates normally.
- Simultaneous push and pop: count is unchanged and both pointers advance. A pop from a full FIFO and a push in the same cycle are both legal.
- Invariants:
  - `drop_cnt ≤ out_cnt`.
  - `out_cnt + fifo_count ≤ DEPTH`.
  - A response with `out_cnt == 0` is a protocol error. The bench flags it; the RTL ignores it.

## Timing
- Reset values:
  - `pc = rsp_pc = RESET_PC`
  - `out_cnt = drop_cnt = 0`
  - FIFO empty
  - `inst_valid = 0`, `inst = 0`, `inst_pc = 0`
  - `imem_req_valid = 0` while `reset` is low
- First cycle after reset deasserts: `imem_req_valid = 1`, `imem_addr = RESET_PC`.
- Latency: a response received at edge N sets `inst_valid` in the cycle after edge N (registered FIFO, no bypass). Minimum request-accept to `inst_valid` is 2 cycles.
- Throughput: 1 instruction/cycle sustained when memory latency ≤ DEPTH−1 and `inst_ready` is held high.
- Redirect in cycle N: `inst_valid` = 0 in N+1. The first request to the target is issued in N+1.
- Reset asserted mid-operation: all state clears asynchronously. In-flight responses arriving after reset releases are the memory's responsibility (the bench must not send them).

## Test plan
- Reset release, memory ready, latency 1, `inst_ready` = 1: requests go to 0x0100_0000, _0004, _0008 on consecutive cycles. `inst_pc` follows in order, and `inst` matches the memory image, one per cycle from the 3rd cycle.
- `inst_ready` = 0 for 10 cycles, latency 1: exactly 4 requests issue, then `imem_req_valid` = 0. FIFO full with PCs 0x0100_0000..000C. On release, 4 pops, then streaming resumes at 0x0100_0010.
- Latency 3 with 3 requests outstanding, redirect to 0x0100_0200: the 3 stale responses are dropped. The next `inst_pc` is 0x0100_0200, and no stale word ever appears on `inst`.
- Redirect in the same cycle as a response, with 1 other outstanding: both words are dropped (`drop_cnt` = 1 after the edge), and the first valid output is the target.
- Redirect to 0x0100_0123: `imem_addr` = 0x0100_0120, `inst_pc` = 0x0100_0120.
- `reset` pulsed low mid-stream with a full FIFO: outputs drop to 0 asynchronously, and after release fetch restarts at `RESET_PC`.
